// File: rtl/periph_responder.sv
// periph_responder: memory-mapped responder beside dmem. Decodes a 16-byte
// register window (TXDATA, STATUS, TIMER, TIMERCMP) and accepts stores into a
// byte-wide TX FIFO and a timer/compare pair. Load data is combinational. The
// FIFO drains over a valid/ready byte stream. A timer match raises a sticky irq.
module periph_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  StoreType,
    input  logic [31:0] DataAdrM,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadDataP,
    output logic        PeriphSel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_TIMER    = 2'd2;
    localparam logic [1:0] REG_TIMERCMP = 2'd3;

    // Merge right-aligned store data into a 32-bit register by store width and lane.
    function automatic logic [31:0] mergeStore(
        input logic [31:0] oldVal,
        input logic [31:0] wData,
        input logic [1:0]  sType,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = oldVal;
        case (sType)
            2'b01: begin
                if (lane[1]) begin
                    res[31:16] = wData[15:0];
                end else begin
                    res[15:0] = wData[15:0];
                end
            end
            2'b10: begin
                case (lane)
                    2'b00:   res[7:0]   = wData[7:0];
                    2'b01:   res[15:8]  = wData[7:0];
                    2'b10:   res[23:16] = wData[7:0];
                    default: res[31:24] = wData[7:0];
                endcase
            end
            default: res = wData;   // word, and 2'b11 treated as word
        endcase
        return res;
    endfunction

    logic [7:0]       fifoMem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W-1:0] wrPtr_r;
    logic [CNT_W-1:0] fifoCount_r;
    logic             overflow_r;
    logic [31:0]      timer_r;
    logic [31:0]      timerCmp_r;
    logic             irq_r;

    logic [1:0]  regIdx_s;
    logic [1:0]  lane_s;
    logic        sel_s;
    logic        wrEn_s;
    logic        fullS_s;
    logic        empty_s;
    logic        pushReq_s;
    logic        pushAcc_s;
    logic        pop_s;
    logic [7:0]  headByte_s;
    logic [4:0]  countField_s;
    logic [31:0] readMux_s;

    assign regIdx_s     = DataAdrM[3:2];
    assign lane_s       = DataAdrM[1:0];
    assign sel_s        = (DataAdrM[31:4] == BASE_ADDR[31:4]);
    assign wrEn_s       = MemWriteM && sel_s;
    assign fullS_s      = (fifoCount_r == CNT_W'(FIFO_DEPTH));
    assign empty_s      = (fifoCount_r == CNT_W'(0));
    assign pop_s        = !empty_s && tx_ready;
    assign pushReq_s    = wrEn_s && (regIdx_s == REG_TXDATA);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign pushAcc_s    = pushReq_s && (!fullS_s || pop_s);
    assign headByte_s   = empty_s ? 8'h00 : fifoMem_r[rdPtr_r];
    assign countField_s = 5'(fifoCount_r);

    assign PeriphSel = sel_s;
    assign tx_valid  = !empty_s;
    assign tx_data   = headByte_s;
    assign irq       = irq_r;

    // Combinational load data: select the addressed register, zero when unselected.
    always_comb begin
        readMux_s = 32'h0000_0000;
        case (regIdx_s)
            REG_TXDATA:   readMux_s = {24'h00_0000, headByte_s};
            REG_STATUS:   readMux_s = {23'h00_0000, countField_s, irq_r, overflow_r, empty_s, fullS_s};
            REG_TIMER:    readMux_s = timer_r;
            REG_TIMERCMP: readMux_s = timerCmp_r;
            default:      readMux_s = 32'h0000_0000;
        endcase
        if (sel_s) begin
            ReadDataP = readMux_s;
        end else begin
            ReadDataP = 32'h0000_0000;
        end
    end

    // TX FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_r[i] <= 8'h00;
            end
            rdPtr_r     <= '0;
            wrPtr_r     <= '0;
            fifoCount_r <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (pushAcc_s) begin
                fifoMem_r[wrPtr_r] <= WriteData[7:0];
                wrPtr_r            <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({pushAcc_s, pop_s})
                2'b10:   fifoCount_r <= fifoCount_r + CNT_W'(1);
                2'b01:   fifoCount_r <= fifoCount_r - CNT_W'(1);
                default: fifoCount_r <= fifoCount_r;
            endcase
            if (wrEn_s && (regIdx_s == REG_STATUS)) begin
                overflow_r <= 1'b0;
            end else if (pushReq_s && !pushAcc_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Free-running timer, compare register and sticky compare interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r    <= 32'h0000_0000;
            timerCmp_r <= 32'hFFFF_FFFF;
            irq_r      <= 1'b0;
        end else begin
            if (wrEn_s && (regIdx_s == REG_TIMER)) begin
                timer_r <= mergeStore(timer_r, WriteData, StoreType, lane_s);
            end else begin
                timer_r <= timer_r + 32'd1;
            end
            if (wrEn_s && (regIdx_s == REG_TIMERCMP)) begin
                timerCmp_r <= mergeStore(timerCmp_r, WriteData, StoreType, lane_s);
                irq_r      <= 1'b0;   // clear beats a coincident match
            end else if (timer_r == timerCmp_r) begin
                irq_r <= 1'b1;
            end
        end
    end

endmodule
